riscv_regfile: RTL

RISCV_REGFILE -- requirements
Module: riscv_regfile

---
 rtl/riscv_regfile.sv | 100 ++++++++++
 1 files changed

// File: rtl/riscv_regfile.sv
// RISC-V integer register file: two combinational read ports, one write port, x0 hardwired to zero.
// Latency: reads are zero-cycle with same-cycle write bypass; writes land on the next rising edge.
// No backpressure; init_busy_o flags the post-reset zeroing sweep, during which writes are dropped.
module riscv_regfile #(
    parameter int REGFILE_COUNT = 32,
    parameter int WORD_SIZE     = 32
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic [$clog2(REGFILE_COUNT)-1:0] read_reg0_i,
    input  logic [$clog2(REGFILE_COUNT)-1:0] read_reg1_i,
    output logic [WORD_SIZE-1:0]             read_data0_o,
    output logic [WORD_SIZE-1:0]             read_data1_o,
    input  logic                             write_en_i,
    input  logic [$clog2(REGFILE_COUNT)-1:0] write_reg_i,
    input  logic [WORD_SIZE-1:0]             write_data_i,
    output logic                             init_busy_o
);

    localparam int            AW        = $clog2(REGFILE_COUNT);
    localparam logic [AW-1:0] LAST_IDX  = AW'(REGFILE_COUNT - 1);
    localparam logic [AW:0]   COUNT_EXT = (AW + 1)'(REGFILE_COUNT);

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    state_t               state;
    logic [AW-1:0]        init_cnt;
    logic [WORD_SIZE-1:0] mem [REGFILE_COUNT];

    // Counter stops at the last index instead of wrapping; RUN is only left through rst_i.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= ST_INIT;
            init_cnt    <= '0;
            init_busy_o <= 1'b1;
        end else if (state == ST_INIT) begin
            if (init_cnt == LAST_IDX) begin
                state       <= ST_RUN;
                init_busy_o <= 1'b0;
            end else begin
                init_cnt <= init_cnt + AW'(1);
            end
        end
    end

    logic                 wr_in_range;
    logic                 run_wr;
    logic                 mem_we;
    logic [AW-1:0]        mem_addr;
    logic [WORD_SIZE-1:0] mem_wdat;

    assign wr_in_range = ({1'b0, write_reg_i} < COUNT_EXT);
    assign run_wr      = (state == ST_RUN) && write_en_i && (write_reg_i != '0) && wr_in_range;

    // rst_i gates the sweep write so the held-in-reset state leaves the array untouched.
    always_comb begin
        mem_we   = 1'b0;
        mem_addr = write_reg_i;
        mem_wdat = write_data_i;
        if (state == ST_INIT) begin
            mem_we   = !rst_i;
            mem_addr = init_cnt;
            mem_wdat = '0;
        end else begin
            mem_we   = run_wr;
        end
    end

    // No reset on the array so it maps onto distributed RAM.
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_wdat;
        end
    end

    logic [AW-1:0]        rd_addr [2];
    logic [WORD_SIZE-1:0] rd_data [2];

    assign rd_addr[0]   = read_reg0_i;
    assign rd_addr[1]   = read_reg1_i;
    assign read_data0_o = rd_data[0];
    assign read_data1_o = rd_data[1];

    for (genvar p = 0; p < 2; p++) begin : g_read
        always_comb begin
            rd_data[p] = '0;
            if ((state == ST_RUN) && (rd_addr[p] != '0) && ({1'b0, rd_addr[p]} < COUNT_EXT)) begin
                if (run_wr && (write_reg_i == rd_addr[p])) begin
                    rd_data[p] = write_data_i;
                end else begin
                    rd_data[p] = mem[rd_addr[p]];
                end
            end
        end
    end

endmodule
